prelude_loader: RTL and testbench
=================================

# prelude_loader

Serial program loader and program memory for the Prelude CPU. Receives a framed program image over a UART line, writes it into a 256x8 program RAM, and holds the CPU in reset while loading. The RAM's asynchronous read port drives the CPU instruction fetch (`pc` -> `ir`), so this block sits directly upstream of the core in place of a fixed ROM.

## Interface
- `CLKS_PER_BIT`, default 234: clock cycles per UART bit. 234 gives 115200 baud at 27 MHz. Legal range is >= 4.
- `SYNC_BYTE`, default 8'hA5: the byte that starts a load.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `uart_rx` in 1: serial input, idle high, 8N1, LSB first. Asynchronous to `clk`.
- `fetch_addr` in 8: CPU program counter.
- `fetch_data` out 8: `ram[fetch_addr]`, combinational.
- `cpu_reset` out 1: holds the core in reset. The top level ORs this with the system `reset`.
- `loading` out 1: high in states LEN and DATA.
- `load_error` out 1: sticky flag for a framing error during a load.
- `load_count` out 8: (bytes written in the current or last load) - 1. Wraps at 256.

## Operation
**UART receiver**
- `uart_rx` passes through a 2-flop synchronizer. Only the synchronized value is used.
- RX_IDLE: a falling edge starts a bit counter. The line is sampled at `CLKS_PER_BIT/2`.
  - If the sample is high, it is a false start: return to RX_IDLE.
- Data bits: 8 samples, one every `CLKS_PER_BIT`, shifted in LSB first.
- Stop bit: sampled one `CLKS_PER_BIT` after the last data bit.
  - Stop high: `rx_valid` pulses for 1 cycle with `rx_byte`.
  - Stop low: `rx_ferr` pulses for 1 cycle instead, and no byte is delivered.
- After the stop sample the receiver returns to RX_IDLE immediately, so back-to-back frames are accepted.

**Load FSM**
- IDLE
  - `rx_valid` && byte == `SYNC_BYTE` -> LEN. Set `cpu_reset`=1 and `load_error`=0.
  - Any other byte, or `rx_ferr`, is ignored.
- LEN
  - `rx_valid`: latch `len` = byte, meaning `len`+1 data bytes (1..256). Clear `addr` and `load_count` to 0. Go to DATA.
- DATA
  - `rx_valid`: `ram[addr]` <= byte, `load_count` <= `addr`, `addr` <= `addr`+1 (8-bit).
  - If `addr` == `len` -> DONE.
- DONE: a single cycle. `cpu_reset` <= 0, then -> IDLE.
- `rx_ferr` in LEN or DATA -> ERROR. Set `load_error`=1. `cpu_reset` stays 1.
- ERROR
  - `cpu_reset` stays high and the core is halted.
  - Only `rx_valid` && `SYNC_BYTE` leaves this state: -> LEN, clearing `load_error`.
  - Other bytes are ignored.
- A `SYNC_BYTE` value received in LEN or DATA is treated as ordinary data. There is no in-band restart.

**RAM**
- 256x8, written synchronously on `clk`, read asynchronously.
- Initial contents are all 0 (opcode 0x00, immediate 0 -> r0, which acts as a NOP).
- `reset` does not clear the RAM. The loaded program survives a reset and reruns.

## Timing
Reset values:
- FSM in IDLE, receiver in RX_IDLE, synchronizer flops = 1.
- `cpu_reset`=0, `loading`=0, `load_error`=0, `load_count`=0, `addr`=0, `len`=0.

Latencies:
- `rx_valid` fires in the cycle of the stop-bit mid-sample. That is about 9.5 bit times plus 2 synchronizer cycles after the start-bit falling edge.
- The RAM write commits on the same edge that consumes `rx_valid`. `fetch_data` reflects it on the next cycle.
- `cpu_reset` rises on the edge after the sync byte's `rx_valid`.
- `cpu_reset` falls 2 edges after the final data byte's `rx_valid` (via DATA -> DONE -> 0).
- `loading` is registered and aligned with the state.

Boundary conditions:
- `len`=8'hFF writes all 256 locations. `addr` wraps to 0 on the final write, and `load_count`=8'hFF.
- `len`=0 writes exactly `ram[0]`.
- `reset` mid-load goes to IDLE with `cpu_reset`=0. Locations already written keep their new values, and the rest keep their old values.
- `reset` mid-frame discards the partial byte.
- `fetch_addr` is honored at all times, including while loading. The core is held in reset during that time.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
1. Reset, then drive `fetch_addr`=0..255 -> `fetch_data`=0 everywhere, `cpu_reset`=0, `loading`=0.
2. Send A5, 02, 3F, 44, C4 -> `ram[0..2]`=3F, 44, C4. `cpu_reset` is high from the cycle after A5 until 2 cycles after the C4 `rx_valid`. `load_count`=2, `load_error`=0.
3. Send A5, FF, then 256 bytes of value i -> `ram[i]`=i for all i, `load_count`=FF, FSM returns to IDLE.
4. Send A5, 03, 11, then a frame with stop bit 0 -> `load_error`=1, `cpu_reset` stays 1, and further non-A5 bytes are ignored. Then send A5, 00, 77 -> `ram[0]`=77, `load_error`=0, `cpu_reset`=0.
5. In IDLE, send bytes 00, 5A, A4 -> no state change and no RAM writes. Also pulse `uart_rx` low for 1 cycle (a glitch shorter than 2 clocks) -> no `rx_valid` (false start).
6. Send A5, 04, 01, 02, then assert `reset` -> IDLE, `cpu_reset`=0, `ram[0..1]`=01, 02, `ram[2]` unchanged. A subsequent full load succeeds.

Source files
------------

// File: rtl/prelude_loader.sv
// prelude_loader: UART program loader plus 256x8 program RAM for the Prelude CPU.
// Latency: a byte is consumed in the stop-bit mid-sample cycle; the RAM write commits on that edge.
// Backpressure: none; the UART cannot be stalled, and bytes outside a framed load are dropped.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   uart_rx         serial input (idle high, 8N1, LSB first), asynchronous to clk
//   fetch_addr      CPU program counter; fetch_data = ram[fetch_addr] (combinational)
//   cpu_reset       holds the core in reset while a load is in progress or has failed
//   loading         high while the loader is in LEN or DATA
//   load_error      sticky framing-error flag, cleared by the next sync byte
//   load_count      index of the last byte written in the current/last load
module prelude_loader #(
  parameter int         CLKS_PER_BIT = 234,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic [7:0] fetch_addr,
  output logic [7:0] fetch_data,
  output logic       cpu_reset,
  output logic       loading,
  output logic       load_error,
  output logic [7:0] load_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     r_rx_state;
  rx_state_t     w_rx_state_nxt;
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_prev;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;

  logic w_fall;
  logic w_cnt_full;
  logic w_cnt_half;
  logic w_rx_cnt_clr;
  logic w_rx_shift_en;
  logic w_rx_valid;
  logic w_rx_ferr;

  assign w_fall     = r_rx_prev & ~r_rx_s2;
  assign w_cnt_full = (r_rx_cnt == LP_FULL);
  assign w_cnt_half = (r_rx_cnt == LP_HALF);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_state_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_fall) w_rx_state_nxt = RX_START;
      // A line already back high at mid-start is a glitch, not a frame.
      RX_START: if (w_cnt_half) w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_cnt_full && (r_rx_bit == 3'd7)) w_rx_state_nxt = RX_STOP;
      RX_STOP:  if (w_cnt_full) w_rx_state_nxt = RX_IDLE;
      default:  w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_cnt_clr  = (w_rx_state_nxt != r_rx_state) || ((r_rx_state == RX_DATA) && w_cnt_full);
    w_rx_shift_en = (r_rx_state == RX_DATA) && w_cnt_full;
    w_rx_valid    = (r_rx_state == RX_STOP) && w_cnt_full && r_rx_s2;
    w_rx_ferr     = (r_rx_state == RX_STOP) && w_cnt_full && !r_rx_s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if ((r_rx_state == RX_IDLE) || w_rx_cnt_clr) r_rx_cnt <= '0;
      else                                         r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state != RX_DATA) r_rx_bit <= '0;
      else if (w_rx_shift_en)    r_rx_bit <= r_rx_bit + 1'b1;
      if (w_rx_shift_en) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
    end
  end

  // ---------------------------------------------------------------- load FSM
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_DONE, ST_ERROR} ld_state_t;

  ld_state_t  r_state;
  ld_state_t  w_state_nxt;
  logic       r_cpu_reset;
  logic       r_loading;
  logic       r_load_error;
  logic [7:0] r_load_count;
  logic [7:0] r_addr;
  logic [7:0] r_len;

  logic       w_sync;
  logic       w_cpu_reset_nxt;
  logic       w_load_error_nxt;
  logic [7:0] w_load_count_nxt;
  logic [7:0] w_addr_nxt;
  logic [7:0] w_len_nxt;
  logic       w_ram_we;

  assign w_sync = w_rx_valid && (r_rx_shift == SYNC_BYTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_sync) w_state_nxt = ST_LEN;
      ST_LEN: begin
        if (w_rx_ferr)       w_state_nxt = ST_ERROR;
        else if (w_rx_valid) w_state_nxt = ST_DATA;
      end
      // The sync value is ordinary data here: no in-band restart.
      ST_DATA: begin
        if (w_rx_ferr)                           w_state_nxt = ST_ERROR;
        else if (w_rx_valid && (r_addr == r_len)) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERROR: if (w_sync) w_state_nxt = ST_LEN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cpu_reset_nxt  = r_cpu_reset;
    w_load_error_nxt = r_load_error;
    w_load_count_nxt = r_load_count;
    w_addr_nxt       = r_addr;
    w_len_nxt        = r_len;
    w_ram_we         = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERROR: begin
        if (w_sync) begin
          w_cpu_reset_nxt  = 1'b1;
          w_load_error_nxt = 1'b0;
        end
      end
      ST_LEN: begin
        if (w_rx_ferr) begin
          w_load_error_nxt = 1'b1;
        end else if (w_rx_valid) begin
          w_len_nxt        = r_rx_shift;
          w_addr_nxt       = '0;
          w_load_count_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_rx_ferr) begin
          w_load_error_nxt = 1'b1;
        end else if (w_rx_valid) begin
          w_ram_we         = !reset;
          w_load_count_nxt = r_addr;
          w_addr_nxt       = r_addr + 8'd1;  // wraps to 0 after a 256-byte load
        end
      end
      ST_DONE:  w_cpu_reset_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_reset  <= 1'b0;
      r_loading    <= 1'b0;
      r_load_error <= 1'b0;
      r_load_count <= '0;
      r_addr       <= '0;
      r_len        <= '0;
    end else begin
      r_cpu_reset  <= w_cpu_reset_nxt;
      r_loading    <= (w_state_nxt == ST_LEN) || (w_state_nxt == ST_DATA);
      r_load_error <= w_load_error_nxt;
      r_load_count <= w_load_count_nxt;
      r_addr       <= w_addr_nxt;
      r_len        <= w_len_nxt;
    end
  end

  // ---------------------------------------------------------------- program RAM
  // Not touched by reset, so a loaded program survives and reruns.
  logic [7:0] r_ram [0:255] = '{default: 8'h00};

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[r_addr] <= r_rx_shift;
  end

  assign fetch_data = r_ram[fetch_addr];
  assign cpu_reset  = r_cpu_reset;
  assign loading    = r_loading;
  assign load_error = r_load_error;
  assign load_count = r_load_count;

endmodule

// File: tb/tb_prelude_loader.sv
module tb_prelude_loader;

  localparam int CPB = 4;

  localparam int EV_START = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_RST   = 3;

  typedef struct {
    int         kind;
    logic [7:0] cnt;
    logic       prev_rst;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] fetch_addr = 8'h00;
  logic [7:0] fetch_data;
  logic       cpu_reset;
  logic       loading;
  logic       load_error;
  logic [7:0] load_count;

  int total = 0;
  int bad = 0;

  ev_t        sb_q[$];
  logic [7:0] exp_mem [0:255];
  logic       m_halted = 1'b0;  // model: core halted by a failed load

  prelude_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_reset  (cpu_reset),
    .loading    (loading),
    .load_error (load_error),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic p_loading = 1'b0;
  logic p_cpu_reset = 1'b0;
  logic pend_fall = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    if (pend_fall) begin
      pend_fall = 1'b0;
      chk("cpu_reset_release", {31'd0, cpu_reset}, 32'd0);
    end
    if ((loading === 1'b1) && (p_loading === 1'b0)) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_load_start: got loading=1, expected 0 (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        chk("start_kind", e.kind, EV_START);
        chk("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("start_prev_cpu_reset", {31'd0, p_cpu_reset}, {31'd0, e.prev_rst});
        chk("start_load_error", {31'd0, load_error}, 32'd0);
      end
    end
    if ((loading === 1'b0) && (p_loading === 1'b1)) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_load_end: got loading=0, expected 1 (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          EV_DONE: begin
            chk("done_kind", e.kind, EV_DONE);
            chk("done_load_count", {24'd0, load_count}, {24'd0, e.cnt});
            chk("done_load_error", {31'd0, load_error}, 32'd0);
            chk("done_cpu_reset_held", {31'd0, cpu_reset}, 32'd1);
            pend_fall = 1'b1;
          end
          EV_ERR: begin
            chk("err_load_error", {31'd0, load_error}, 32'd1);
            chk("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
          end
          EV_RST: begin
            chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
            chk("rst_load_error", {31'd0, load_error}, 32'd0);
          end
          default: chk("end_kind", e.kind, EV_DONE);
        endcase
      end
    end
    p_loading   = loading;
    p_cpu_reset = cpu_reset;
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int gap);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    uart_rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_ev(input int kind, input logic [7:0] cnt, input logic prev_rst);
    ev_t e;
    e.kind = kind; e.cnt = cnt; e.prev_rst = prev_rst;
    sb_q.push_back(e);
  endtask

  // Complete load of len+1 bytes taken from data[]
  task automatic do_load(input logic [7:0] len, input logic [7:0] data [0:255], input logic rand_gap);
    push_ev(EV_START, 8'd0, m_halted);
    push_ev(EV_DONE, len, 1'b0);
    send_frame(8'hA5, 1'b1, rand_gap ? $urandom_range(0, 3) : 0);
    send_frame(len, 1'b1, rand_gap ? $urandom_range(0, 3) : 0);
    for (int i = 0; i <= int'(len); i++) begin
      send_frame(data[i], 1'b1, rand_gap ? $urandom_range(0, 3) : 0);
      exp_mem[i] = data[i];
    end
    m_halted = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_mem(input string tag);
    int errs;
    errs = 0;
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      fetch_addr = 8'(a);
      #1;
      total++;
      if (fetch_data !== exp_mem[a]) begin
        bad++; errs++;
        if (errs <= 8)
          $display("FAIL %s ram[%0h]: got %0h, expected %0h", tag, a, fetch_data, exp_mem[a]);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    chk({tag, "_loading"}, {31'd0, loading}, 32'd0);
    chk({tag, "_load_error"}, {31'd0, load_error}, 32'd0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    logic [7:0] d [0:255];
    logic [7:0] b;
    int len;
    int wait_cyc;

    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset state and blank RAM
    check_idle("rst");
    chk("rst_load_count", {24'd0, load_count}, 32'd0);
    check_mem("blank");

    // 2: short load A5 02 3F 44 C4
    d[0] = 8'h3F; d[1] = 8'h44; d[2] = 8'hC4;
    do_load(8'h02, d, 1'b0);
    check_idle("load3");
    chk("load3_count", {24'd0, load_count}, 32'd2);
    check_mem("load3");

    // random-content loads of random length, random inter-frame gaps
    for (int k = 0; k < 3; k++) begin
      len = $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) d[i] = 8'($urandom);
      do_load(8'(len), d, 1'b1);
      chk("rand_count", {24'd0, load_count}, len);
    end
    check_mem("rand");

    // 3: full 256-byte load, ram[i] = i
    for (int i = 0; i < 256; i++) d[i] = 8'(i);
    do_load(8'hFF, d, 1'b0);
    check_idle("full");
    chk("full_count", {24'd0, load_count}, 32'hFF);
    check_mem("full");

    // 4: framing error in DATA, ignored bytes while halted, then recovery
    push_ev(EV_START, 8'd0, m_halted);
    push_ev(EV_ERR, 8'd0, 1'b0);
    send_frame(8'hA5, 1'b1, 2);
    send_frame(8'h03, 1'b1, 2);
    send_frame(8'h11, 1'b1, 2);
    exp_mem[0] = 8'h11;
    send_frame(8'h5C, 1'b0, 6);
    m_halted = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_frame(b, 1'b1, 2);
    end
    repeat (6) @(negedge clk);
    chk("halt_load_error", {31'd0, load_error}, 32'd1);
    chk("halt_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("halt_loading", {31'd0, loading}, 32'd0);
    d[0] = 8'h77;
    do_load(8'h00, d, 1'b0);
    check_idle("recover");
    chk("recover_count", {24'd0, load_count}, 32'd0);
    check_mem("recover");

    // 5: non-sync bytes and a one-cycle glitch in IDLE do nothing
    send_frame(8'h00, 1'b1, 3);
    send_frame(8'h5A, 1'b1, 3);
    send_frame(8'hA4, 1'b1, 3);
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check_idle("ignore");
    check_mem("ignore");
    // receiver must be back in RX_IDLE: a load right after the glitch works
    d[0] = 8'hE1; d[1] = 8'h1E;
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    do_load(8'h01, d, 1'b0);
    chk("glitch_count", {24'd0, load_count}, 32'd1);

    // 6: reset in the middle of a load
    push_ev(EV_START, 8'd0, m_halted);
    push_ev(EV_RST, 8'd0, 1'b0);
    send_frame(8'hA5, 1'b1, 1);
    send_frame(8'h04, 1'b1, 1);
    send_frame(8'h01, 1'b1, 1);
    send_frame(8'h02, 1'b1, 8);
    exp_mem[0] = 8'h01; exp_mem[1] = 8'h02;
    chk("pre_rst_loading", {31'd0, loading}, 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_halted = 1'b0;
    check_idle("midrst");
    chk("midrst_count", {24'd0, load_count}, 32'd0);
    check_mem("midrst");
    for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
    do_load(8'h05, d, 1'b1);
    check_idle("after");
    check_mem("after");

    wait_cyc = 0;
    while ((sb_q.size() != 0) && (wait_cyc < 200)) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
